// File: rtl/hybrid_control_dt_pkg.sv
// rtl/hybrid_control_dt_pkg.sv - state, MOSFET and sigma encodings for the hybrid controller
package hybrid_ctrl_pkg;

   // Automaton states; 2-state mode only visits P and N.
   typedef enum logic [1:0] {
      ST_P  = 2'b00,
      ST_Z1 = 2'b01,
      ST_N  = 2'b10,
      ST_Z2 = 2'b11
   } state_t;

   // Gate patterns {M3,M2,M1,M0}.
   localparam logic [3:0] MOS_P   = 4'b1001;
   localparam logic [3:0] MOS_Z1  = 4'b0010;
   localparam logic [3:0] MOS_N   = 4'b0110;
   localparam logic [3:0] MOS_Z2  = 4'b0011;
   localparam logic [3:0] MOS_OFF = 4'b0000;

   // Two's complement sigma values.
   localparam logic [1:0] SIG_POS  = 2'b01;
   localparam logic [1:0] SIG_ZERO = 2'b00;
   localparam logic [1:0] SIG_NEG  = 2'b11;

   // Full-precision width of X1*sin - X2*cos.
   function automatic int surf_width(input int dw, input int cw);
      return dw + 2 * cw + 1;
   endfunction

   function automatic logic [3:0] mos_pattern(input state_t s);
      case (s)
         ST_P:    return MOS_P;
         ST_Z1:   return MOS_Z1;
         ST_N:    return MOS_N;
         default: return MOS_Z2;
      endcase
   endfunction

   function automatic logic [1:0] sigma_of(input state_t s);
      case (s)
         ST_P:    return SIG_POS;
         ST_N:    return SIG_NEG;
         default: return SIG_ZERO;
      endcase
   endfunction

endpackage

// File: rtl/hybrid_control_dt_half_plane_sign.sv
// rtl/hybrid_control_dt_half_plane_sign.sv - stages 2-3: surface value and its registered sign
module half_plane_sign
   import hybrid_ctrl_pkg::*;
#(
   parameter int DW = 14,
   parameter int CW = 32
) (
   input  logic                  clock,
   input  logic                  resetn,
   input  logic signed [DW+CW-1:0] x1,
   input  logic signed [DW+CW-1:0] x2,
   input  logic signed [CW-1:0]  sin_v,
   input  logic signed [CW-1:0]  cos_v,
   output logic                  neg
);

   localparam int SW = surf_width(DW, CW);

   logic signed [SW-1:0] surf;

   // Operands are sign-extended to the full surface width so nothing is truncated.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         surf <= '0;
         neg  <= 1'b0;
      end else begin
         surf <= SW'(x1) * SW'(sin_v) - SW'(x2) * SW'(cos_v);
         neg  <= surf[SW-1];
      end
   end

endmodule

// File: rtl/hybrid_control_dt.sv
// rtl/hybrid_control_dt.sv - sigma automaton with debounce, minimum dwell and dead time
module hybrid_control_dt
   import hybrid_ctrl_pkg::*;
#(
   parameter int                   DW        = 14,
   parameter int                   CW        = 32,
   parameter logic signed [CW-1:0] MU_Z1     = 86,
   parameter logic signed [CW-1:0] MU_Z2     = 90,
   parameter int                   DEBOUNCE  = 2,
   parameter int                   MIN_DWELL = 200,
   parameter int                   DEAD_TIME = 4,
   parameter int                   DTW       = 16
) (
   input  logic                 i_clock,
   input  logic                 i_RESET,
   input  logic                 i_enable,
   input  logic                 i_mode,
   input  logic signed [DW-1:0] i_vC,
   input  logic signed [DW-1:0] i_iC,
   input  logic signed [CW-1:0] i_cos_a,
   input  logic signed [CW-1:0] i_sin_a,
   input  logic signed [CW-1:0] i_cos_b,
   input  logic signed [CW-1:0] i_sin_b,
   output logic [3:0]           o_MOSFET,
   output logic [1:0]           o_sigma,
   output logic [1:0]           o_state,
   output logic                 o_jump,
   output logic                 o_deadtime
);

   localparam int             XW        = DW + CW;
   localparam logic [DTW-1:0] DEB_MAX   = DTW'(DEBOUNCE);
   localparam logic [DTW-1:0] DWELL_MIN = DTW'(MIN_DWELL);
   localparam logic [DTW-1:0] DT_LOAD   = DTW'(DEAD_TIME);
   localparam logic [DTW-1:0] DWELL_SAT = '1;

   logic signed [XW-1:0] x1, x2;
   logic                 a_neg, b_neg;
   state_t               state, next_state;
   logic [DTW-1:0]       dwell, deb, deb_inc, dt_cnt, dt_next;
   logic                 cond, jump;

   // Stage 1: scaled capacitor voltage and inductor current, shared by both surfaces.
   always_ff @(posedge i_clock or negedge i_RESET) begin
      if (!i_RESET) begin
         x1 <= '0;
         x2 <= '0;
      end else begin
         x1 <= XW'(MU_Z1) * XW'(i_vC);
         x2 <= XW'(MU_Z2) * XW'(i_iC);
      end
   end

   half_plane_sign #(.DW(DW), .CW(CW)) u_surf_a (
      .clock(i_clock), .resetn(i_RESET), .x1(x1), .x2(x2),
      .sin_v(i_sin_a), .cos_v(i_cos_a), .neg(a_neg)
   );

   half_plane_sign #(.DW(DW), .CW(CW)) u_surf_b (
      .clock(i_clock), .resetn(i_RESET), .x1(x1), .x2(x2),
      .sin_v(i_sin_b), .cos_v(i_cos_b), .neg(b_neg)
   );

   // Jump decision: the debounce count after this edge must reach DEBOUNCE and dwell must be long enough.
   always_comb begin
      cond       = 1'b0;
      jump       = 1'b0;
      next_state = state;
      case (state)
         ST_P:    cond = !a_neg;
         ST_Z1:   cond = !b_neg;
         ST_N:    cond = a_neg;
         default: cond = b_neg;
      endcase
      deb_inc = (deb >= DEB_MAX) ? DEB_MAX : deb + DTW'(1);
      if (i_enable) begin
         if ((state == ST_Z1 || state == ST_Z2) && i_mode) begin
            jump       = 1'b1;
            next_state = ST_N;
         end else if (cond && deb_inc == DEB_MAX && dwell >= DWELL_MIN) begin
            jump = 1'b1;
            case (state)
               ST_P:    next_state = i_mode ? ST_N : ST_Z1;
               ST_Z1:   next_state = ST_N;
               ST_N:    next_state = i_mode ? ST_P : ST_Z2;
               default: next_state = ST_P;
            endcase
         end
      end
      if (!i_enable || jump)
         dt_next = DT_LOAD;
      else if (dt_cnt != '0)
         dt_next = dt_cnt - DTW'(1);
      else
         dt_next = '0;
   end

   // Automaton state, counters and registered outputs; disable holds the dead-time counter loaded.
   always_ff @(posedge i_clock or negedge i_RESET) begin
      if (!i_RESET) begin
         state    <= ST_N;
         dwell    <= '0;
         deb      <= '0;
         dt_cnt   <= DT_LOAD;
         o_MOSFET <= MOS_OFF;
         o_sigma  <= SIG_NEG;
         o_jump   <= 1'b0;
      end else begin
         state    <= next_state;
         o_sigma  <= sigma_of(next_state);
         o_jump   <= jump;
         dt_cnt   <= dt_next;
         o_MOSFET <= (i_enable && dt_next == '0) ? mos_pattern(next_state) : MOS_OFF;
         if (!i_enable || jump || !cond)
            deb <= '0;
         else
            deb <= deb_inc;
         if (jump)
            dwell <= '0;
         else if (i_enable && dwell != DWELL_SAT)
            dwell <= dwell + DTW'(1);
      end
   end

   assign o_state    = state;
   assign o_deadtime = (dt_cnt != '0);

endmodule

// File: tb/tb_hybrid_control_dt.sv
// tb/tb_hybrid_control_dt.sv - directed self-checking bench for hybrid_control_dt
module tb_hybrid_control_dt;

   logic               clk = 1'b0;
   logic               rst_n;
   logic               enable, mode;
   logic signed [13:0] vc, ic;
   logic signed [31:0] cos_a, sin_a, cos_b, sin_b;
   logic [3:0]         mos;
   logic [1:0]         sigma, state;
   logic               jump, deadtime;
   int                 vectors = 0;
   int                 miscompares = 0;
   int                 n;

   hybrid_control_dt #(.MIN_DWELL(8)) dut (
      .i_clock(clk), .i_RESET(rst_n), .i_enable(enable), .i_mode(mode),
      .i_vC(vc), .i_iC(ic),
      .i_cos_a(cos_a), .i_sin_a(sin_a), .i_cos_b(cos_b), .i_sin_b(sin_b),
      .o_MOSFET(mos), .o_sigma(sigma), .o_state(state),
      .o_jump(jump), .o_deadtime(deadtime)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_jump(output int cnt);
      cnt = 0;
      do begin
         tick();
         cnt++;
      end while (jump !== 1'b1 && cnt < 60);
      check("jump_seen", jump, 1'b1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0; enable = 1'b1; mode = 1'b0;
      vc = 0; ic = 0;
      sin_a = 1; cos_a = 0; sin_b = 0; cos_b = 1;
      repeat (3) tick();
      check("rst_state", state, 2'b10);
      check("rst_sigma", sigma, 2'b11);
      check("rst_mos", mos, 4'b0000);
      check("rst_jump", jump, 1'b0);
      check("rst_deadtime", deadtime, 1'b1);

      // release: four dead-time cycles then N pattern
      rst_n = 1'b1;
      for (int k = 0; k < 4; k++) begin
         check("t1_dead_mos", mos, 4'b0000);
         check("t1_no_jump", jump, 1'b0);
         tick();
      end
      check("t1_mos_n", mos, 4'b0110);
      check("t1_deadtime_off", deadtime, 1'b0);
      check("t1_sigma", sigma, 2'b11);
      for (int k = 0; k < 8; k++) begin
         tick();
         check("t1_zero_surface_no_jump", jump, 1'b0);
      end

      // single-cycle glitch of a_neg in N: no jump
      vc = -1; tick(); vc = 0;
      for (int k = 0; k < 10; k++) begin
         tick();
         check("t3_glitch_no_jump", jump, 1'b0);
      end
      check("t3_glitch_state", state, 2'b10);

      // held step: jump to Z2 on the fifth edge
      vc = -1;
      repeat (4) tick();
      check("t3_hold_state_4", state, 2'b10);
      check("t3_hold_jump_4", jump, 1'b0);
      tick();
      check("t3_state_z2", state, 2'b11);
      check("t3_jump", jump, 1'b1);
      check("t3_sigma_zero", sigma, 2'b00);
      check("t3_mos_off", mos, 4'b0000);
      check("t3_deadtime_on", deadtime, 1'b1);

      // Z2 -> P: condition ready early, dwell holds it to the ninth edge
      ic = 1;
      tick();
      check("t3_jump_pulse", jump, 1'b0);
      check("t3_dead_mos_1", mos, 4'b0000);
      tick(); tick();
      check("t3_dead_mos_3", mos, 4'b0000);
      check("t3_deadtime_3", deadtime, 1'b1);
      tick();
      check("t3_mos_z2", mos, 4'b0011);
      check("t3_deadtime_off", deadtime, 1'b0);
      repeat (4) tick();
      check("t2_dwell_hold", state, 2'b11);
      tick();
      check("t2_state_p", state, 2'b00);
      check("t2_jump_p", jump, 1'b1);
      check("t2_sigma_p", sigma, 2'b01);

      // enable dropped in P for 50 cycles
      repeat (4) tick();
      check("t5_mos_p", mos, 4'b1001);
      repeat (6) tick();
      enable = 1'b0; vc = 0;
      tick();
      check("t5_dis_mos", mos, 4'b0000);
      check("t5_dis_deadtime", deadtime, 1'b1);
      check("t5_dis_state", state, 2'b00);
      repeat (39) tick();
      check("t5_frozen_state", state, 2'b00);
      check("t5_frozen_sigma", sigma, 2'b01);
      check("t5_frozen_mos", mos, 4'b0000);
      vc = -1;
      repeat (10) tick();
      enable = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         check("t5_reen_dead_mos", mos, 4'b0000);
      end
      tick();
      check("t5_reen_mos_p", mos, 4'b1001);
      check("t5_reen_state", state, 2'b00);

      // asynchronous reset in the middle of dead time in P
      enable = 1'b0; tick(); enable = 1'b1;
      tick(); tick();
      check("t6_pre_deadtime", deadtime, 1'b1);
      check("t6_pre_state", state, 2'b00);
      #3 rst_n = 1'b0;
      #1;
      check("t6_async_state", state, 2'b10);
      check("t6_async_sigma", sigma, 2'b11);
      check("t6_async_mos", mos, 4'b0000);
      check("t6_async_deadtime", deadtime, 1'b1);
      vc = 0;
      tick(); tick();
      rst_n = 1'b1;
      for (int k = 0; k < 4; k++) begin
         check("t6_restart_dead_mos", mos, 4'b0000);
         tick();
      end
      check("t6_restart_mos_n", mos, 4'b0110);

      // 2-state mode: only P <-> N
      mode = 1'b1; vc = -1;
      wait_jump(n);
      check("t4_first_latency", n, 5);
      check("t4_state_p", state, 2'b00);
      check("t4_sigma_p", sigma, 2'b01);
      vc = 1;
      tick();
      check("t4_jump_one_cycle", jump, 1'b0);
      wait_jump(n);
      check("t4_p_to_n_latency", n, 8);
      check("t4_state_n", state, 2'b10);
      check("t4_sigma_n", sigma, 2'b11);
      vc = -1;
      wait_jump(n);
      check("t4_n_to_p_latency", n, 9);
      check("t4_state_p2", state, 2'b00);

      // back to 4-state: P -> Z1 -> N -> Z2, then mode switch in Z2
      mode = 1'b0; vc = 1;
      wait_jump(n);
      check("t2_p_to_z1_latency", n, 9);
      check("t2_state_z1", state, 2'b01);
      check("t2_sigma_z1", sigma, 2'b00);
      repeat (10) tick();
      check("t2_z1_hold", state, 2'b01);
      ic = -1;
      wait_jump(n);
      check("t2_z1_to_n_latency", n, 5);
      check("t2_state_n", state, 2'b10);
      vc = -1;
      wait_jump(n);
      check("t2_n_to_z2_latency", n, 9);
      check("t2_state_z2", state, 2'b11);
      repeat (3) tick();
      check("t4_z2_hold", state, 2'b11);
      mode = 1'b1;
      tick();
      check("t4_mode_switch_state", state, 2'b10);
      check("t4_mode_switch_jump", jump, 1'b1);
      check("t4_mode_switch_sigma", sigma, 2'b11);

      // full-precision surface: large negative SA whose low 32 bits are positive
      mode = 1'b0; vc = 0;
      repeat (12) tick();
      check("fp_idle_state", state, 2'b10);
      ic = 8191; sin_a = 0; cos_a = 32'sh7FFF_FFFF;
      wait_jump(n);
      check("fp_latency", n, 5);
      check("fp_state_z2", state, 2'b11);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/hybrid_control_dt.md
Name: hybrid_control_dt

Overview:
Parametrised successor of the mixed-angle hybrid controller for the resonant converter. It drives the sigma automaton (+1 -> 0 -> -1 -> 0) from two half-plane jump surfaces, one for ZVS and one for ZVS+2*phi. Compared with the previous controller it adds:
- generic data and coefficient widths
- a selectable 2-state/4-state mode
- a per-surface debounce counter
- a minimum dwell time between jumps
- programmable dead-time insertion on the MOSFET commands

It sits between the ADC front-end and the gate drivers. Sin/cos come from an external trigonometry_deg pair.

Parameters:
DW, 14, signed width of i_vC / i_iC
CW, 32, signed width of mu coefficients and sin/cos inputs
MU_Z1, 86, voltage scaling (CW-bit signed)
MU_Z2, 90, current scaling (CW-bit signed)
DEBOUNCE, 2, consecutive cycles a jump condition must hold (>=1)
MIN_DWELL, 200, minimum cycles in a state before the next jump (>=1)
DEAD_TIME, 4, cycles with all MOSFETs off after every state change (>=0)
DTW, 16, width of the dwell and dead-time counters

Ports:
i_clock  in  1  system clock
i_RESET  in  1  asynchronous active-low reset
i_enable  in  1  1 = run automaton; 0 = freeze state, MOSFETs off
i_mode  in  1  0 = 4-state (+1,0,-1,0); 1 = 2-state (+1,-1)
i_vC  in  DW  signed capacitor voltage (z1)
i_iC  in  DW  signed inductor current (z2)
i_cos_a / i_sin_a  in  CW  signed cos/sin(ZVS+2*phi), surface A
i_cos_b / i_sin_b  in  CW  signed cos/sin(ZVS), surface B
o_MOSFET  out  4  gate commands
o_sigma  out  2  signed sigma: 01=+1, 00=0, 11=-1
o_state  out  2  encoded state
o_jump  out  1  one-cycle pulse on every state change
o_deadtime  out  1  high while dead time is active

Behaviour:
- Reset: i_RESET is asynchronous and active-low; clock is i_clock. Reset values:
  - state = N (2'b10), o_sigma = 2'b11, o_MOSFET = 4'b0000, o_jump = 0
  - dead-time counter = DEAD_TIME, so o_deadtime = 1 when DEAD_TIME > 0
  - dwell counter = 0
  - debounce counters = 0
  - pipeline registers = 0
- Reset asserted mid-operation returns to this state immediately. No partial dead time is preserved.
- States and encoding:
  - P = 00 (sigma +1)
  - Z1 = 01 (0)
  - N = 10 (-1)
  - Z2 = 11 (0)
- MOSFET patterns {M3,M2,M1,M0}: P = 1001, Z1 = 0010, N = 0110, Z2 = 0011.
- Arithmetic pipeline (3 cycles, all signed, full precision, no truncation):
  - Cycle 1: X1 = MU_Z1*vC and X2 = MU_Z2*iC, each DW+CW bits.
  - Cycle 2: SA = X1*sin_a - X2*cos_a and SB = X1*sin_b - X2*cos_b, each DW+2*CW+1 bits.
  - Cycle 3: register sign bits a_neg = SA[MSB] and b_neg = SB[MSB].
- Jump conditions, 4-state mode:
  - P->Z1 when !a_neg
  - Z1->N when !b_neg
  - N->Z2 when a_neg
  - Z2->P when b_neg
- Jump conditions, 2-state mode:
  - P->N when !a_neg
  - N->P when a_neg
  - Z1/Z2 go to N on the next cycle, with no dwell/debounce check.
- Debounce: a per-state condition counter increments while the current condition holds, clears when it fails, and clears on any jump. It saturates at DEBOUNCE.
- Jump rule: a jump fires on the clock edge where debounce count == DEBOUNCE, dwell >= MIN_DWELL, and i_enable = 1.
- Dwell counter: clears on a jump, else increments and saturates at 2^DTW-1.
- i_mode is sampled only on a jump edge or when idle in Z1/Z2. Changing it never creates an extra jump.
- On a jump:
  - o_jump = 1 for exactly one cycle.
  - Dead-time counter loads DEAD_TIME; o_MOSFET = 0000 while counter != 0.
  - The new pattern is driven in the first cycle the counter is 0.
  - With DEAD_TIME = 0 the new pattern appears in the same cycle as o_jump.
- A jump arriving during dead time (dwell permitting) reloads the dead-time counter. The MOSFETs stay off.
- i_enable = 0:
  - state, dwell and debounce are frozen (debounce cleared)
  - o_MOSFET = 0000 and o_sigma reflects the held state
  - on re-enable, the dead-time counter is loaded before the pattern is driven
- o_sigma and o_state are registered and change on the jump edge.

Decomposition:
- Package hybrid_ctrl_pkg holds:
  - state encodings P/Z1/N/Z2
  - MOSFET pattern constants
  - sigma encodings
  - the function computing the surface width DW+2*CW+1
- One sub-module, half_plane_sign: the 3-stage pipeline returning one registered sign bit. It is instantiated twice (A, B) with shared X1/X2 stage-1 logic passed in.

Test Plan:
1. Reset, then release with DEAD_TIME=4 and i_vC=i_iC=0 -> o_MOSFET=0000 for 4 cycles, then 0110; o_sigma=11; o_jump never asserted.
2. 4-state with MIN_DWELL=8, DEBOUNCE=2, ZVS=10 deg, phi=20 deg, sinusoidal vC/iC of amplitude 4000, 200-cycle period -> state sequence N,Z2,P,Z1,N repeats; each o_jump is followed by 4 cycles of 0000; dwell between jumps is >= 8.
3. Single-cycle glitch flipping a_neg in state N with DEBOUNCE=2 -> no jump; a 2-cycle hold -> jump to Z2 five cycles after the input step (3 pipeline + 2 debounce).
4. i_mode=1 during the same stimulus -> only P<->N transitions, o_sigma alternates 01/11, never 00; switching i_mode mid-run in Z1 -> next cycle state N.
5. i_enable dropped in P for 50 cycles -> o_MOSFET=0000, state held at 00; re-enable -> 4 dead-time cycles, then 1001.
6. i_RESET asserted asynchronously mid dead time in state P -> outputs immediately take the reset values; after release the counter restarts at DEAD_TIME.
